// File: rtl/seq_sub16_if.sv
// Handshake and operand/result bundle for seq_sub16.
// The master side requests subtractions and the slave side (the subtractor) returns results.
interface seq_sub16_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        bin;
  logic [15:0] D;
  logic        Bout;
  logic        Z;
  logic        V;
  logic        busy;
  logic        done;

  modport master (
    output start, A, B, bin,
    input  D, Bout, Z, V, busy, done
  );

  modport slave (
    input  start, A, B, bin,
    output D, Bout, Z, V, busy, done
  );
endinterface

// File: rtl/seq_sub16.sv
// Multi-cycle 16-bit subtractor: D = A - B - bin computed as A + ~B + ~bin, SLICE_W bits per clock.
// Define SEQ_SUB16_OVF_EN to enable the signed-overflow output V; otherwise V stays 0.
module seq_sub16 #(
  parameter int SLICE_W = 4
) (
  input  logic clk,
  input  logic rst,
  seq_sub16_if.slave bus
);

  localparam int N     = 16 / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic [15:0]        op_a_reg, op_b_reg, res_reg, res_next;
  logic [15:0]        d_reg;
  logic               carry_reg, bout_reg, z_reg, v_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               accept, last;
  logic [SLICE_W-1:0] a_slice, b_slice;
  logic [SLICE_W:0]   slice_sum;
  logic               v_next;

  assign last = (cnt_reg == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One shared SLICE_W-bit adder; the counter selects which slice it works on.
  always_comb begin
    a_slice   = op_a_reg[32'(cnt_reg) * SLICE_W +: SLICE_W];
    b_slice   = op_b_reg[32'(cnt_reg) * SLICE_W +: SLICE_W];
    slice_sum = (SLICE_W + 1)'(a_slice) + (SLICE_W + 1)'(b_slice) + (SLICE_W + 1)'(carry_reg);
    res_next  = res_reg;
    res_next[32'(cnt_reg) * SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
  end

`ifdef SEQ_SUB16_OVF_EN
  // Carry into bit 15 is recovered from the low SLICE_W-1 bits of the top slice.
  logic c_msb_in;
  generate
    if (SLICE_W == 1) begin : g_tap_w1
      assign c_msb_in = carry_reg;
    end else begin : g_tap_wn
      logic [SLICE_W-1:0] low_sum;
      assign low_sum  = SLICE_W'(a_slice[SLICE_W-2:0]) + SLICE_W'(b_slice[SLICE_W-2:0])
                      + SLICE_W'(carry_reg);
      assign c_msb_in = low_sum[SLICE_W-1];
    end
  endgenerate
  assign v_next = c_msb_in ^ slice_sum[SLICE_W];
`else
  assign v_next = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      d_reg     <= '0;
      bout_reg  <= 1'b0;
      z_reg     <= 1'b0;
      v_reg     <= 1'b0;
    end else if (accept) begin
      op_a_reg  <= bus.A;
      op_b_reg  <= ~bus.B;
      carry_reg <= ~bus.bin;
      cnt_reg   <= '0;
      res_reg   <= '0;
    end else if (state_reg == RUN) begin
      res_reg   <= res_next;
      carry_reg <= slice_sum[SLICE_W];
      cnt_reg   <= cnt_reg + 1'b1;
      if (last) begin
        d_reg    <= res_next;
        bout_reg <= ~slice_sum[SLICE_W];
        z_reg    <= (res_next == 16'h0000);
        v_reg    <= v_next;
      end
    end
  end

  assign bus.D    = d_reg;
  assign bus.Bout = bout_reg;
  assign bus.Z    = z_reg;
  assign bus.V    = v_reg;
  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);

endmodule

// File: tb/tb_seq_sub16.sv
// Directed bench for seq_sub16: vector table on the default slice width plus
// reset, back-to-back and slice-width corner sequences.
module tb_seq_sub16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_sub16_if bus ();
  seq_sub16_if bus1 ();
  seq_sub16_if bus16 ();

  seq_sub16 #(.SLICE_W(4))  dut   (.clk(clk), .rst(rst), .bus(bus));
  seq_sub16 #(.SLICE_W(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  seq_sub16 #(.SLICE_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

`ifdef SEQ_SUB16_OVF_EN
  localparam logic V_OVF = 1'b1;
`else
  localparam logic V_OVF = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        z;
    logic        v;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns after the edge at which done appears.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output int cycles);
    logic [15:0] prev_d;
    prev_d    = bus.D;
    bus.A     = a;
    bus.B     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
    bus.bin   = 1'($urandom);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      check("d_hold_in_run", 32'(bus.D), 32'(prev_d));
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int l1, l16;
    logic [15:0] d1, d16;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, V_OVF};
    vecs[3] = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, V_OVF};

    bus.start = 1'b0;   bus.A = '0;   bus.B = '0;   bus.bin = 1'b0;
    bus1.start = 1'b0;  bus1.A = '0;  bus1.B = '0;  bus1.bin = 1'b0;
    bus16.start = 1'b0; bus16.A = '0; bus16.B = '0; bus16.bin = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_D", 32'(bus.D), 32'h0);
    check("rst_Bout", 32'(bus.Bout), 32'd0);
    check("rst_Z", 32'(bus.Z), 32'd0);
    check("rst_V", 32'(bus.V), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, cyc);
      $display("vec %0d: %h - %h - %0d -> D=%h Bout=%0d Z=%0d V=%0d latency=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].bin, bus.D, bus.Bout, bus.Z, bus.V, cyc);
      check("vec_latency", 32'(cyc), 32'd4);
      check("vec_done", 32'(bus.done), 32'd1);
      check("vec_busy_done", 32'(bus.busy), 32'd0);
      check("vec_D", 32'(bus.D), 32'(vecs[i].d));
      check("vec_Bout", 32'(bus.Bout), 32'(vecs[i].bout));
      check("vec_Z", 32'(bus.Z), 32'(vecs[i].z));
      check("vec_V", 32'(bus.V), 32'(vecs[i].v));
      @(posedge clk); #1;
      check("vec_done_pulse", 32'(bus.done), 32'd0);
      check("vec_hold_D", 32'(bus.D), 32'(vecs[i].d));
    end

    // Reset in the middle of a RUN: outputs clear at once and no done appears.
    bus.A = 16'hFFFF; bus.B = 16'h0001; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_D", 32'(bus.D), 32'h0);
    check("mid_rst_Bout", 32'(bus.Bout), 32'd0);
    check("mid_rst_Z", 32'(bus.Z), 32'd0);
    check("mid_rst_V", 32'(bus.V), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_hold_done", 32'(bus.done), 32'd0);
      check("rst_hold_busy", 32'(bus.busy), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_done", 32'(bus.done), 32'd0);
    run_op(16'h1234, 16'h0234, 1'b0, cyc);
    $display("post-reset op: D=%h latency=%0d", bus.D, cyc);
    check("post_rst_latency", 32'(cyc), 32'd4);
    check("post_rst_D", 32'(bus.D), 32'h1000);
    @(posedge clk); #1;

    // start held through RUN is ignored; start in DONE launches the next op.
    bus.A = 16'h0005; bus.B = 16'h0004; bus.bin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.A = 16'h0003; bus.B = 16'h0005; bus.bin = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    $display("held-start op: D=%h Z=%0d latency=%0d", bus.D, bus.Z, cyc);
    check("held_latency", 32'(cyc), 32'd4);
    check("held_D", 32'(bus.D), 32'h0000);
    check("held_Z", 32'(bus.Z), 32'd1);
    check("held_Bout", 32'(bus.Bout), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'd1);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    $display("back-to-back op: D=%h Bout=%0d cycles_after_done=%0d", bus.D, bus.Bout, cyc);
    check("b2b_spacing", 32'(cyc), 32'd5);
    check("b2b_D", 32'(bus.D), 32'hFFFE);
    check("b2b_Bout", 32'(bus.Bout), 32'd1);
    check("b2b_Z", 32'(bus.Z), 32'd0);
    @(posedge clk); #1;

    // Same operation on the 1-bit and 16-bit slice variants.
    bus1.A = 16'h1234;  bus1.B = 16'h0234;  bus1.bin = 1'b0;  bus1.start = 1'b1;
    bus16.A = 16'h1234; bus16.B = 16'h0234; bus16.bin = 1'b0; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus16.start = 1'b0;
    l1 = -1; l16 = -1; d1 = '0; d16 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus1.done && l1 < 0) begin
        l1 = c;
        d1 = bus1.D;
      end
      if (bus16.done && l16 < 0) begin
        l16 = c;
        d16 = bus16.D;
      end
    end
    $display("slice_w=1: D=%h latency=%0d  slice_w=16: D=%h latency=%0d", d1, l1, d16, l16);
    check("w1_latency", 32'(l1), 32'd16);
    check("w1_D", 32'(d1), 32'h1000);
    check("w16_latency", 32'(l16), 32'd1);
    check("w16_D", 32'(d16), 32'h1000);
    check("w1_Bout", 32'(bus1.Bout), 32'd0);
    check("w16_Bout", 32'(bus16.Bout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
